// File: rtl/uart_send_server_if.sv
// Send-request interface between the core and the UART send server.
//   en   : core requests a byte write (master -> slave)
//   data : byte to transmit (master -> slave)
//   busy : server FIFO is full, requests are ignored (slave -> master)
interface uart_send_server_if;
   logic       en;
   logic [7:0] data;
   logic       busy;

   modport master (output en, output data, input busy);
   modport slave  (input en, input data, output busy);
endinterface

// File: rtl/uart_send_server.sv
// UART send server: buffers bytes from the core in a FIFO and serialises
// them as 8N1 frames on txd.
//   clock   : single clock, all state updates on its rising edge
//   reset   : synchronous, active-high reset
//   io_send : responder end of the send-request interface (en, data, busy)
//   txd     : UART transmit line, registered, idle high
//   drained : FIFO empty and transmitter idle
module uart_send_server #(
   parameter int unsigned CLK_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                clock,
   input  logic                reset,
   uart_send_server_if.slave   io_send,
   output logic                txd,
   output logic                drained
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
   localparam logic [15:0]     BitLast = 16'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // FIFO storage and bookkeeping
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            push;
   logic            pop;

   // transmitter
   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        bit_end;

   // busy comes straight from the registered count, never from en
   assign full         = (count_q == CntFull);
   assign io_send.busy = full;
   assign push         = io_send.en && !full;
   assign txd          = txd_q;
   assign drained      = (count_q == '0) && (state_q == StIdle);
   assign bit_end      = (baud_q == BitLast);

   // Transmitter next-state. txd_d is derived from the current state, so the
   // line lags the state register by one cycle; every bit still lasts exactly
   // CLK_PER_BIT cycles and consecutive frames stay contiguous.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q + 16'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      txd_d     = 1'b1;
      pop       = 1'b0;

      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[head_q];
               state_d = StStart;
            end
         end
         StStart: begin
            txd_d = 1'b0;
            if (bit_end) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = StData;
            end
         end
         StData: begin
            txd_d = shift_q[0];
            if (bit_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            txd_d = 1'b1;
            if (bit_end) begin
               baud_d = '0;
               // chain straight into the next frame when more bytes wait
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[head_q];
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            baud_d  = '0;
         end
      endcase
   end

   // FIFO pointer/count next-state; pop never happens on an empty FIFO
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
      end
   end

   // storage needs no reset; count guards every read
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_q[tail_q] <= io_send.data;
      end
   end

endmodule

// File: tb/tb_uart_send_server.sv
module tb_uart_send_server;

   localparam int unsigned Cpb      = 4;
   localparam int unsigned Depth    = 4;
   localparam int          FrameLen = 10 * Cpb;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic txd;
   logic drained;

   uart_send_server_if io_send();

   uart_send_server #(
      .CLK_PER_BIT (Cpb),
      .FIFO_DEPTH  (Depth)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .io_send (io_send),
      .txd     (txd),
      .drained (drained)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] mq[$];     // bytes held in the modelled FIFO
   logic [7:0] sb_q[$];   // bytes expected on the line, in order
   int         edge_n    = 0;
   bit         m_idle    = 1'b1;
   int         frame_end = 0;
   bit         cur_v     = 1'b0;
   bit         prev_v    = 1'b0;
   int         cur_p     = 0;
   int         prev_p    = 0;
   logic [7:0] cur_b     = 8'h00;
   logic [7:0] prev_b    = 8'h00;
   bit         acc_last  = 1'b0;
   bit         rx_abort  = 1'b0;
   bit         checking  = 1'b0;
   bit         exp_txd     = 1'b1;
   bit         exp_busy    = 1'b0;
   bit         exp_drained = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // line level of a frame t cycles after it started: start, d0..d7, stop
   function automatic bit frame_bit(input logic [7:0] b, input int t);
      int k;
      k = t / Cpb;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   // Frame-level model: a byte is popped when the line is free, each frame
   // takes FrameLen cycles, and the line shows frame position t two cycles
   // after the edge that accepted the byte into an idle, empty server.
   initial begin
      forever begin
         bit do_pop;
         bit do_push;
         int t;
         @(posedge clock);
         edge_n++;
         if (reset) begin
            mq.delete();
            sb_q.delete();
            m_idle   = 1'b1;
            cur_v    = 1'b0;
            prev_v   = 1'b0;
            acc_last = 1'b0;
            rx_abort = 1'b1;
            checking = 1'b1;
         end else begin
            do_push = io_send.en && (mq.size() < Depth);
            do_pop  = (mq.size() > 0) && (m_idle || edge_n == frame_end);
            if (!do_pop && !m_idle && edge_n == frame_end) m_idle = 1'b1;
            if (do_pop) begin
               prev_v    = cur_v;
               prev_p    = cur_p;
               prev_b    = cur_b;
               cur_v     = 1'b1;
               cur_p     = edge_n;
               cur_b     = mq.pop_front();
               frame_end = edge_n + FrameLen;
               m_idle    = 1'b0;
            end
            if (do_push) begin
               mq.push_back(io_send.data);
               sb_q.push_back(io_send.data);
            end
            acc_last = do_push;
         end
         exp_txd = 1'b1;
         if (!reset) begin
            t = edge_n - 1 - cur_p;
            if (cur_v && t >= 0 && t < FrameLen) begin
               exp_txd = frame_bit(cur_b, t);
            end else begin
               t = edge_n - 1 - prev_p;
               if (prev_v && t >= 0 && t < FrameLen) exp_txd = frame_bit(prev_b, t);
            end
         end
         exp_busy    = (mq.size() == Depth);
         exp_drained = (mq.size() == 0) && m_idle;
      end
   end

   // cycle monitor: outputs against the model, sampled mid-cycle
   initial begin
      forever begin
         @(negedge clock);
         if (checking) begin
            check("txd", 32'(txd), 32'(exp_txd));
            check("busy", 32'(io_send.busy), 32'(exp_busy));
            check("drained", 32'(drained), 32'(exp_drained));
         end
      end
   end

   // UART receiver: decodes frames and pops the scoreboard per byte
   initial begin
      int         cnt;
      int         k;
      bit         active;
      logic [7:0] sh;
      cnt    = 0;
      active = 1'b0;
      sh     = 8'h00;
      forever begin
         @(negedge clock);
         if (rx_abort) begin
            rx_abort = 1'b0;
            active   = 1'b0;
         end else if (!active) begin
            if (checking && txd == 1'b0) begin
               active = 1'b1;
               cnt    = 0;
            end
         end else begin
            cnt++;
            if (cnt % Cpb == Cpb / 2) begin
               k = cnt / Cpb;
               if (k == 0) begin
                  check("rx_start", 32'(txd), 32'd0);
               end else if (k <= 8) begin
                  sh[k-1] = txd;
               end else begin
                  check("rx_stop", 32'(txd), 32'd1);
                  if (sb_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL rx_unexpected: got byte %0h expected no frame", sh);
                  end else begin
                     check("rx_byte", 32'(sh), 32'(sb_q.pop_front()));
                  end
                  active = 1'b0;
               end
            end
         end
      end
   end

   // hold en with b until the model accepts it
   task automatic send(input logic [7:0] b);
      int guard;
      guard        = 0;
      io_send.en   = 1'b1;
      io_send.data = b;
      do begin
         @(negedge clock);
         guard++;
      end while (!acc_last && guard < 200);
      if (!acc_last) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: byte %0h not accepted after %0d cycles, required acceptance", b, guard);
      end
   endtask

   task automatic idle(input int n);
      io_send.en = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_empty(input string name);
      int guard;
      guard      = 0;
      io_send.en = 1'b0;
      while (sb_q.size() != 0 && guard < 3000) begin
         @(negedge clock);
         guard++;
      end
      check(name, 32'(sb_q.size()), 32'd0);
      idle(4);
   endtask

   initial begin
      io_send.en   = 1'b0;
      io_send.data = 8'h00;
      reset        = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(io_send.busy), 32'd0);
      check("rst_drained", 32'(drained), 32'd1);

      // single byte
      send(8'hA5);
      idle(45);
      check("a5_drained", 32'(drained), 32'd1);

      // back-to-back frames
      send(8'h00);
      send(8'hFF);
      send(8'h55);
      wait_empty("b2b_sent");

      // fill past capacity; the held byte waits for the end-of-stop pop
      for (int i = 0; i < 7; i++) send(8'(8'h10 + i));
      wait_empty("full_sent");

      // pointer wrap
      for (int i = 0; i < 10; i++) send(8'(i));
      wait_empty("wrap_sent");

      // random bytes and gaps
      repeat (25) begin
         send(8'($urandom));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 60)));
      end
      wait_empty("rand_sent");

      // reset in the middle of DATA with two bytes queued
      send(8'h3C);
      send(8'h11);
      send(8'h22);
      idle(15);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midrst_txd", 32'(txd), 32'd1);
      check("midrst_busy", 32'(io_send.busy), 32'd0);
      check("midrst_drained", 32'(drained), 32'd1);
      idle(120);
      check("midrst_quiet", 32'(drained), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
